fifo_flex: RTL and testbench

Synchronous single-clock FIFO, parametrised successor to the team's basic FIFO. Adds a selectable first-word-fall-through read mode, an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, pass-through write when full and reading, and sticky overflow/underflow error flags. It sits between any two same-clock producer/consumer stages in the datapath.

---
 rtl/fifo_flex_if.sv | 34 +++
 rtl/fifo_flex.sv | 91 +++++++++
 tb/tb_fifo_flex.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flex_if.sv
// Producer/consumer bundle for fifo_flex: write side, read side, status and error flags.
// The FIFO end takes the slave modport; whoever drives it takes master.
interface fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_flush;
  logic             i_clr_err;
  logic [WIDTH-1:0] i_wdata;
  logic             i_wen;
  logic             o_full;
  logic             o_almost_full;
  logic [WIDTH-1:0] o_rdata;
  logic             i_ren;
  logic             o_empty;
  logic             o_almost_empty;
  logic [CW-1:0]    o_count;
  logic             o_overflow;
  logic             o_underflow;

  modport master (
    output i_flush, i_clr_err, i_wdata, i_wen, i_ren,
    input  o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_flush, i_clr_err, i_wdata, i_wen, i_ren,
    output o_full, o_almost_full, o_rdata, o_empty, o_almost_empty,
           o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with optional FWFT, occupancy/threshold flags, flush, sticky errors.
// Read latency 1 (FWFT=0) or 0 (FWFT=1); full drops writes unless a pop frees a slot that cycle.
module fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  fifo_flex_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P    = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_P    = PW'(AE_THRESH);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ovf;
  logic             r_udf;

  logic [PW-1:0]    w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_ovf_set;
  logic             w_udf_set;

  // The extra pointer MSB makes count = wptr - rptr unambiguous between empty and full.
  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == DEPTH_P);
  assign w_rd_acc  = !bus.i_flush && bus.i_ren && !w_empty;
  assign w_wr_acc  = !bus.i_flush && bus.i_wen && (!w_full || w_rd_acc);
  assign w_ovf_set = !bus.i_flush && bus.i_wen && !w_wr_acc;
  assign w_udf_set = !bus.i_flush && bus.i_ren && w_empty;

  assign bus.o_count        = w_count;
  assign bus.o_empty        = w_empty;
  assign bus.o_full         = w_full;
  assign bus.o_almost_full  = (w_count >= AF_P);
  assign bus.o_almost_empty = (w_count <= AE_P);
  assign bus.o_overflow     = r_ovf;
  assign bus.o_underflow    = r_udf;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
      r_udf  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (bus.i_flush) begin
        r_rptr <= r_wptr;
      end else begin
        if (w_wr_acc) begin
          r_mem[r_wptr[AW-1:0]] <= bus.i_wdata;
          r_wptr                <= r_wptr + PW'(1);
        end
        if (w_rd_acc) begin
          r_rptr <= r_rptr + PW'(1);
        end
      end
      // A new error event in the same cycle as a clear keeps the flag set.
      r_ovf <= w_ovf_set | (r_ovf & ~bus.i_clr_err);
      r_udf <= w_udf_set | (r_udf & ~bus.i_clr_err);
    end
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.o_rdata = r_mem[r_rptr[AW-1:0]];
  end else begin : g_reg
    logic [WIDTH-1:0] r_rdata;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_rdata <= '0;
      end else if (w_rd_acc) begin
        r_rdata <= r_mem[r_rptr[AW-1:0]];
      end
    end
    assign bus.o_rdata = r_rdata;
  end
endmodule

// File: tb/tb_fifo_flex.sv
// Directed scenarios on DEPTH=16 FWFT=0/1, then a random soak of DEPTH {16,2} x FWFT {0,1}
// instances against a circular-buffer reference model.
module tb_fifo_flex;
  logic       clk = 1'b0;
  logic       rst, flush, clr, wen, ren;
  logic [7:0] wdata;

  int nvec = 0;
  int nerr = 0;

  logic [4:0] o_cnt [4];
  logic [7:0] o_rd  [4];
  logic       o_emp [4];
  logic       o_ful [4];
  logic       o_af  [4];
  logic       o_ae  [4];
  logic       o_ov  [4];
  logic       o_un  [4];

  // Reference model state, one slot per instance
  logic [7:0] mbuf [4][16];
  int         mhead [4];
  int         msize [4];
  logic [7:0] mrd   [4];
  logic       mov   [4];
  logic       mun   [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g16
    fifo_flex_if #(.WIDTH(8), .DEPTH(16)) bus ();
    assign bus.i_flush   = flush;
    assign bus.i_clr_err = clr;
    assign bus.i_wdata   = wdata;
    assign bus.i_wen     = wen;
    assign bus.i_ren     = ren;
    fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(g), .AF_THRESH(14), .AE_THRESH(2)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    assign o_cnt[g] = bus.o_count;
    assign o_rd[g]  = bus.o_rdata;
    assign o_emp[g] = bus.o_empty;
    assign o_ful[g] = bus.o_full;
    assign o_af[g]  = bus.o_almost_full;
    assign o_ae[g]  = bus.o_almost_empty;
    assign o_ov[g]  = bus.o_overflow;
    assign o_un[g]  = bus.o_underflow;
  end

  for (genvar g = 0; g < 2; g++) begin : g2
    fifo_flex_if #(.WIDTH(8), .DEPTH(2)) bus ();
    assign bus.i_flush   = flush;
    assign bus.i_clr_err = clr;
    assign bus.i_wdata   = wdata;
    assign bus.i_wen     = wen;
    assign bus.i_ren     = ren;
    fifo_flex #(.WIDTH(8), .DEPTH(2), .FWFT(g), .AF_THRESH(2), .AE_THRESH(0)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    assign o_cnt[g+2] = {3'b000, bus.o_count};
    assign o_rd[g+2]  = bus.o_rdata;
    assign o_emp[g+2] = bus.o_empty;
    assign o_ful[g+2] = bus.o_full;
    assign o_af[g+2]  = bus.o_almost_full;
    assign o_ae[g+2]  = bus.o_almost_empty;
    assign o_ov[g+2]  = bus.o_overflow;
    assign o_un[g+2]  = bus.o_underflow;
  end

  function automatic int dep(int k); return (k < 2) ? 16 : 2; endfunction
  function automatic int fw(int k);  return k % 2;            endfunction
  function automatic int afth(int k); return (k < 2) ? 14 : 2; endfunction
  function automatic int aeth(int k); return (k < 2) ? 2 : 0;  endfunction

  function automatic logic [5:0] st(int k);
    return {o_emp[k], o_ful[k], o_af[k], o_ae[k], o_ov[k], o_un[k]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; flush = 0; clr = 0; wen = 0; ren = 0; wdata = 8'h00;
  endtask

  // Advances the model of instance k by one clock using the currently driven inputs.
  task automatic model_step(int k);
    bit racc, wacc, so, su;
    int d;
    d = dep(k); so = 0; su = 0;
    if (rst) begin
      msize[k] = 0; mhead[k] = 0; mrd[k] = 8'h00; mov[k] = 0; mun[k] = 0;
    end else begin
      if (flush) begin
        msize[k] = 0;
      end else begin
        racc = ren && (msize[k] > 0);
        wacc = wen && ((msize[k] < d) || racc);
        so = wen && !wacc;
        su = ren && (msize[k] == 0);
        if (racc) begin
          if (fw(k) == 0) mrd[k] = mbuf[k][mhead[k]];
          mhead[k] = (mhead[k] + 1) % d;
          msize[k] = msize[k] - 1;
        end
        if (wacc) begin
          mbuf[k][(mhead[k] + msize[k]) % d] = wdata;
          msize[k] = msize[k] + 1;
        end
      end
      mov[k] = (mov[k] && !clr) || so;
      mun[k] = (mun[k] && !clr) || su;
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1; tick(); rst = 0;
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if (st(k) !== 6'b100100) begin
        nerr++; $display("FAIL reset_flags[%0d] got %b want 100100", k, st(k));
      end
      nvec++;
      if (o_cnt[k] !== 5'd0) begin
        nerr++; $display("FAIL reset_count[%0d] got %0d want 0", k, o_cnt[k]);
      end
      nvec++;
      if (o_rd[k] !== 8'h00) begin
        nerr++; $display("FAIL reset_rdata[%0d] got %h want 00", k, o_rd[k]);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      wen = 1; wdata = 8'(i); tick();
      nvec++;
      if (o_cnt[0] !== 5'(i + 1)) begin
        nerr++; $display("FAIL fill_count got %0d want %0d", o_cnt[0], i + 1);
      end
      nvec++;
      if ({o_af[0], o_ful[0], o_emp[0]} !== {(i + 1 >= 14), (i + 1 == 16), 1'b0}) begin
        nerr++; $display("FAIL fill_flags at %0d got af/full/empty=%b%b%b", i + 1, o_af[0], o_ful[0], o_emp[0]);
      end
    end
    wen = 0;
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      ren = 1; tick();
      nvec++;
      if (o_rd[0] !== 8'(i)) begin
        nerr++; $display("FAIL drain_data got %h want %h", o_rd[0], 8'(i));
      end
      nvec++;
      if (o_cnt[0] !== 5'(15 - i)) begin
        nerr++; $display("FAIL drain_count got %0d want %0d", o_cnt[0], 15 - i);
      end
    end
    ren = 0;
    nvec++;
    if (o_emp[0] !== 1'b1) begin
      nerr++; $display("FAIL drain_empty got %b want 1", o_emp[0]);
    end
  endtask

  task automatic test_fwft_head();
    wen = 1; wdata = 8'hA5; tick(); wen = 0;
    nvec++;
    if ({o_emp[1], o_cnt[1], o_rd[1]} !== {1'b0, 5'd1, 8'hA5}) begin
      nerr++; $display("FAIL fwft_head got empty=%b count=%0d rdata=%h want 0/1/a5", o_emp[1], o_cnt[1], o_rd[1]);
    end
    ren = 1; tick(); ren = 0;
    nvec++;
    if (o_emp[1] !== 1'b1) begin
      nerr++; $display("FAIL fwft_pop_empty got %b want 1", o_emp[1]);
    end
  endtask

  task automatic test_full_passthrough();
    for (int i = 0; i < 16; i++) begin
      wen = 1; wdata = 8'(8'h10 + i); tick();
    end
    wen = 1; ren = 1; wdata = 8'h55; tick();
    nvec++;
    if ({o_cnt[0], o_ov[0], o_rd[0]} !== {5'd16, 1'b0, 8'h10}) begin
      nerr++; $display("FAIL passthru got count=%0d ovf=%b rdata=%h want 16/0/10", o_cnt[0], o_ov[0], o_rd[0]);
    end
    ren = 0; wdata = 8'h66; tick(); wen = 0;
    nvec++;
    if ({o_cnt[0], o_ov[0]} !== {5'd16, 1'b1}) begin
      nerr++; $display("FAIL overflow_set got count=%0d ovf=%b want 16/1", o_cnt[0], o_ov[0]);
    end
    tick();
    nvec++;
    if (o_ov[0] !== 1'b1) begin
      nerr++; $display("FAIL overflow_sticky got %b want 1", o_ov[0]);
    end
    clr = 1; tick(); clr = 0;
    nvec++;
    if (o_ov[0] !== 1'b0) begin
      nerr++; $display("FAIL overflow_clear got %b want 0", o_ov[0]);
    end
    for (int i = 0; i < 16; i++) begin
      ren = 1; tick();
      nvec++;
      if (o_rd[0] !== ((i < 15) ? 8'(8'h11 + i) : 8'h55)) begin
        nerr++; $display("FAIL passthru_order at %0d got %h", i, o_rd[0]);
      end
    end
    ren = 0;
  endtask

  task automatic test_empty_underflow();
    wen = 1; ren = 1; wdata = 8'h77; tick(); wen = 0; ren = 0;
    nvec++;
    if ({o_cnt[0], o_un[0], o_rd[0]} !== {5'd1, 1'b1, 8'h55}) begin
      nerr++; $display("FAIL underflow got count=%0d udf=%b rdata=%h want 1/1/55", o_cnt[0], o_un[0], o_rd[0]);
    end
    clr = 1; tick(); clr = 0;
    nvec++;
    if (o_un[0] !== 1'b0) begin
      nerr++; $display("FAIL underflow_clear got %b want 0", o_un[0]);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) begin
      wen = 1; wdata = 8'(8'h81 + i); tick();
    end
    wen = 0;
    nvec++;
    if (o_cnt[0] !== 5'd5) begin
      nerr++; $display("FAIL flush_pre_count got %0d want 5", o_cnt[0]);
    end
    flush = 1; wen = 1; wdata = 8'hEE; tick(); flush = 0; wen = 0;
    nvec++;
    if ({o_emp[0], o_cnt[0], o_rd[0]} !== {1'b1, 5'd0, 8'h55}) begin
      nerr++; $display("FAIL flush got empty=%b count=%0d rdata=%h want 1/0/55", o_emp[0], o_cnt[0], o_rd[0]);
    end
    wen = 1; wdata = 8'h31; tick(); wen = 0;
    ren = 1; tick(); ren = 0;
    nvec++;
    if ({o_rd[0], o_emp[0]} !== {8'h31, 1'b1}) begin
      nerr++; $display("FAIL flush_nowrite got rdata=%h empty=%b want 31/1", o_rd[0], o_emp[0]);
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      wen = 1; ren = 1; wdata = 8'(8'h90 + i); tick();
    end
    rst = 1; tick(); idle();
    for (int k = 0; k < 4; k++) begin
      nvec++;
      if ({st(k), o_cnt[k], o_rd[k]} !== {6'b100100, 5'd0, 8'h00}) begin
        nerr++; $display("FAIL midstream_reset[%0d] got flags=%b count=%0d rdata=%h", k, st(k), o_cnt[k], o_rd[k]);
      end
    end
  endtask

  task automatic test_wrap_stress();
    logic [5:0] exp_st;
    idle(); rst = 1;
    for (int k = 0; k < 4; k++) model_step(k);
    tick();
    for (int c = 0; c < 6000; c++) begin
      // Alternate write-heavy and read-heavy phases so both full and empty are visited.
      if (((c / 200) % 2) == 0) begin
        wen = ($urandom_range(0, 3) != 0); ren = ($urandom_range(0, 3) == 0);
      end else begin
        wen = ($urandom_range(0, 3) == 0); ren = ($urandom_range(0, 3) != 0);
      end
      wdata = 8'($urandom);
      flush = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 49) == 0);
      rst   = ($urandom_range(0, 1499) == 0);
      for (int k = 0; k < 4; k++) model_step(k);
      tick();
      for (int k = 0; k < 4; k++) begin
        exp_st = {msize[k] == 0, msize[k] == dep(k), msize[k] >= afth(k),
                  msize[k] <= aeth(k), mov[k], mun[k]};
        nvec++;
        if ({st(k), o_cnt[k]} !== {exp_st, 5'(msize[k])}) begin
          nerr++; $display("FAIL stress_state[%0d] cyc %0d got %b/%0d want %b/%0d", k, c, st(k), o_cnt[k], exp_st, msize[k]);
        end
        if (fw(k) == 0 || msize[k] > 0) begin
          nvec++;
          if (o_rd[k] !== ((fw(k) == 0) ? mrd[k] : mbuf[k][mhead[k]])) begin
            nerr++; $display("FAIL stress_data[%0d] cyc %0d got %h", k, c, o_rd[k]);
          end
        end
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_fill();
    test_drain();
    test_fwft_head();
    test_full_passthrough();
    test_empty_underflow();
    test_flush();
    test_reset_midstream();
    test_wrap_stress();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
